// File: rtl/adc_conv_sequencer_if.sv
// SAR core handshake and averaged-result bus for adc_conv_sequencer.
// ADC_SEQ_MINMAX_EN adds the sample_min/sample_max result signals.
interface adc_conv_sequencer_if #(
  parameter int unsigned DATA_W = 8
);
  logic              adc_start;
  logic              adc_done;
  logic [DATA_W-1:0] adc_data;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
`ifdef ADC_SEQ_MINMAX_EN
  logic [DATA_W-1:0] sample_min;
  logic [DATA_W-1:0] sample_max;

  modport master (
    output adc_start, sample_out, sample_valid, sample_min, sample_max,
    input  adc_done, adc_data
  );
  modport slave (
    input  adc_start, sample_out, sample_valid, sample_min, sample_max,
    output adc_done, adc_data
  );
`else
  modport master (
    output adc_start, sample_out, sample_valid,
    input  adc_done, adc_data
  );
  modport slave (
    input  adc_start, sample_out, sample_valid,
    output adc_done, adc_data
  );
`endif
endinterface

// File: rtl/adc_conv_sequencer.sv
// Burst-averaging conversion scheduler for the SAR ADC core (ADC_Clk domain).
// Optional macro ADC_SEQ_MINMAX_EN tracks min/max of the averaged results.
module adc_conv_sequencer #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned PERIOD   = 1000,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                   ADC_Clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   single_shot,
  input  logic                   clear_err,
  adc_conv_sequencer_if.master   sar,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   overrun
);
  localparam int unsigned ACC_W  = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;
  localparam int unsigned PCNT_W = $clog2(PERIOD);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  BURST_LEN = CNT_W'(1 << AVG_LOG2);
  localparam logic [PCNT_W-1:0] P_LAST    = PCNT_W'(PERIOD - 1);
  // Trip one cycle early so the registered flag rises TIMEOUT cycles after adc_start.
  localparam logic [TMR_W-1:0]  T_TRIP    = TMR_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_CONVERT, S_OUTPUT} state_e;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                timeout_err_q, timeout_err_d;
  logic                overrun_q, overrun_d;

  logic                tick;
  logic                upd;
  logic                timeout_set;
  logic [ACC_W-1:0]    sum;
  logic [DATA_W-1:0]   avg;
  logic [CNT_W-1:0]    cnt_inc;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    sample_d    = sample_q;
    upd         = 1'b0;
    timeout_set = 1'b0;

    tick = enable && (pcnt_q == P_LAST);
    if (!enable || (pcnt_q == P_LAST)) pcnt_d = '0;
    else                               pcnt_d = pcnt_q + 1'b1;

    sum     = acc_q + ACC_W'(sar.adc_data);
    avg     = sum[ACC_W-1:AVG_LOG2];
    cnt_inc = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (tick || single_shot) state_d = S_START;
      end
      S_START: begin
        timer_d = '0;
        state_d = S_CONVERT;
      end
      S_CONVERT: begin
        timer_d = timer_q + 1'b1;
        if (sar.adc_done) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          if (cnt_inc == BURST_LEN) begin
            // Result registered here so it is presented alongside sample_valid.
            state_d  = S_OUTPUT;
            sample_d = avg;
            upd      = 1'b1;
          end else begin
            state_d = S_START;
          end
        end else if (timer_q == T_TRIP) begin
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_OUTPUT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    timeout_err_d = timeout_set || (timeout_err_q && !clear_err);
    overrun_d     = (tick && (state_q != S_IDLE)) || (overrun_q && !clear_err);
  end

  always_ff @(posedge ADC_Clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      pcnt_q        <= '0;
      timer_q       <= '0;
      sample_q      <= '0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      pcnt_q        <= pcnt_d;
      timer_q       <= timer_d;
      sample_q      <= sample_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign sar.adc_start    = (state_q == S_START);
  assign sar.sample_valid = (state_q == S_OUTPUT);
  assign sar.sample_out   = sample_q;
  assign busy             = (state_q != S_IDLE);
  assign timeout_err      = timeout_err_q;
  assign overrun          = overrun_q;

`ifdef ADC_SEQ_MINMAX_EN
  logic [DATA_W-1:0] min_q, min_d, min_base;
  logic [DATA_W-1:0] max_q, max_d, max_base;

  always_comb begin
    min_base = clear_err ? '1 : min_q;
    max_base = clear_err ? '0 : max_q;
    min_d    = min_base;
    max_d    = max_base;
    if (upd) begin
      if (avg < min_base) min_d = avg;
      if (avg > max_base) max_d = avg;
    end
  end

  always_ff @(posedge ADC_Clk) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign sar.sample_min = min_q;
  assign sar.sample_max = max_q;
`endif
endmodule
